// File: rtl/trng_conditioner_pkg.sv
// trng_pkg: shared types and constants for the TRNG conditioner.
//   trng_state_e      : conditioner FSM states
//   CAUSE_RCT/APT     : bit positions inside alarm_cause
//   DEF_*             : default parameter values
package trng_pkg;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        RUN     = 2'd1,
        ALARM   = 2'd2
    } trng_state_e;

    localparam int CAUSE_RCT = 0;
    localparam int CAUSE_APT = 1;

    localparam int DEF_BUF_DEPTH    = 16;
    localparam int DEF_RCT_CUTOFF   = 32;
    localparam int DEF_APT_WINDOW   = 512;
    localparam int DEF_APT_CUTOFF   = 410;
    localparam int DEF_STARTUP_BITS = 1024;

endpackage

// File: rtl/trng_conditioner_if.sv
// trng_conditioner_if: sampler, downstream RNG and alarm-control signals of
// the conditioner.
//   raw_bit/raw_valid   : raw sampler strobe
//   trng_next/trng_bit  : one-bit-per-request delivery, bit_avail qualifies
//   ready               : conditioner is delivering (RUN)
//   alarm/alarm_cause   : sticky health-test failure, alarm_clr clears it
// master = environment side, slave = conditioner side.
interface trng_conditioner_if;
    logic       raw_bit;
    logic       raw_valid;
    logic       trng_next;
    logic       alarm_clr;
    logic       trng_bit;
    logic       bit_avail;
    logic       ready;
    logic       alarm;
    logic [1:0] alarm_cause;

    modport master (
        output raw_bit, raw_valid, trng_next, alarm_clr,
        input  trng_bit, bit_avail, ready, alarm, alarm_cause
    );

    modport slave (
        input  raw_bit, raw_valid, trng_next, alarm_clr,
        output trng_bit, bit_avail, ready, alarm, alarm_cause
    );
endinterface

// File: rtl/trng_conditioner_health_test.sv
// trng_health_test: continuous repetition-count and adaptive-proportion tests
// on the raw sampler stream.
//   clk, reset_n : clock, async active-low reset
//   raw_bit      : raw sample, qualified by raw_valid
//   raw_valid    : sample strobe
//   clear        : synchronous clear of all test state
//   freeze       : hold all test state (strobes ignored)
//   rct_fail     : pulse, this strobe completes a run of RCT_CUTOFF equal bits
//   apt_fail     : pulse, this strobe closes a window with too many 1s or 0s
// Fail pulses are combinational from the current strobe so the caller can
// register the alarm on the same edge that consumes the failing strobe.
module trng_health_test
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW = DEF_APT_WINDOW,
    parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_bit,
    input  logic raw_valid,
    input  logic clear,
    input  logic freeze,
    output logic rct_fail,
    output logic apt_fail
);
    localparam int AW = $clog2(APT_WINDOW) + 1;
    localparam logic [AW-1:0] WIN      = AW'(APT_WINDOW);
    localparam logic [AW-1:0] WIN_LAST = AW'(APT_WINDOW - 1);
    localparam logic [AW-1:0] CUT      = AW'(APT_CUTOFF);

    logic          strobe;
    logic [7:0]    rct_cnt, rct_cnt_nxt;
    logic          prev_bit;
    logic [AW-1:0] apt_pos, apt_ones, ones_nxt;
    logic          win_end;

    assign strobe = raw_valid & ~freeze;

    always_comb begin
        // rct_cnt == 0 means no previous bit since reset/clear.
        if (rct_cnt == 8'd0 || raw_bit != prev_bit)
            rct_cnt_nxt = 8'd1;
        else if (rct_cnt == 8'hff)
            rct_cnt_nxt = rct_cnt;
        else
            rct_cnt_nxt = rct_cnt + 8'd1;
        ones_nxt = apt_ones + AW'(raw_bit);
        win_end  = (apt_pos == WIN_LAST);
        rct_fail = strobe && (rct_cnt_nxt == 8'(RCT_CUTOFF));
        apt_fail = strobe && win_end && ((ones_nxt >= CUT) || ((WIN - ones_nxt) >= CUT));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rct_cnt  <= '0;
            prev_bit <= 1'b0;
            apt_pos  <= '0;
            apt_ones <= '0;
        end else if (clear) begin
            rct_cnt  <= '0;
            prev_bit <= 1'b0;
            apt_pos  <= '0;
            apt_ones <= '0;
        end else if (strobe) begin
            rct_cnt  <= rct_cnt_nxt;
            prev_bit <= raw_bit;
            if (win_end) begin
                apt_pos  <= '0;
                apt_ones <= '0;
            end else begin
                apt_pos  <= apt_pos + AW'(1);
                apt_ones <= ones_nxt;
            end
        end
    end
endmodule

// File: rtl/trng_conditioner.sv
// trng_conditioner: health-tests raw ring-oscillator samples, von Neumann
// debiases them and buffers the result for the word-assembling RNG stage.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : raw_bit/raw_valid in; trng_next in, trng_bit/bit_avail out;
//                  ready, alarm, alarm_cause out; alarm_clr in
// Any health failure moves to ALARM, flushes the buffer and stops delivery
// until alarm_clr, after which STARTUP_BITS raw bits are tested again.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
    parameter int RCT_CUTOFF   = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW   = DEF_APT_WINDOW,
    parameter int APT_CUTOFF   = DEF_APT_CUTOFF,
    parameter int STARTUP_BITS = DEF_STARTUP_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    trng_conditioner_if.slave   bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    trng_state_e   state_q, state_d;
    logic [15:0]   su_cnt_q, su_cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          rct_fail, apt_fail, fail, clear;

    logic          pair_vld_q, pair_bit_q;
    logic          run_strobe, push, do_push, pop;
    logic [BUF_DEPTH-1:0] mem;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] cnt_q;

    assign clear = (state_q == ALARM) && bus.alarm_clr;
    assign fail  = rct_fail | apt_fail;

    trng_health_test #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_bit   (bus.raw_bit),
        .raw_valid (bus.raw_valid),
        .clear     (clear),
        .freeze    (state_q == ALARM),
        .rct_fail  (rct_fail),
        .apt_fail  (apt_fail)
    );

    // ---------------- FSM ----------------
    always_comb begin
        state_d  = state_q;
        su_cnt_d = su_cnt_q;
        cause_d  = cause_q;
        case (state_q)
            STARTUP: begin
                if (fail) begin
                    state_d = ALARM;
                    cause_d = cause_q | {apt_fail, rct_fail};
                end else if (bus.raw_valid) begin
                    if (su_cnt_q == 16'(STARTUP_BITS - 1)) begin
                        state_d  = RUN;
                        su_cnt_d = '0;
                    end else begin
                        su_cnt_d = su_cnt_q + 16'd1;
                    end
                end
            end
            RUN: begin
                if (fail) begin
                    state_d = ALARM;
                    cause_d = cause_q | {apt_fail, rct_fail};
                end
            end
            ALARM: begin
                if (bus.alarm_clr) begin
                    state_d  = STARTUP;
                    cause_d  = '0;
                    su_cnt_d = '0;
                end
            end
            default: state_d = STARTUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= STARTUP;
            su_cnt_q <= '0;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            su_cnt_q <= su_cnt_d;
            cause_q  <= cause_d;
        end
    end

    // ---------------- von Neumann debiaser ----------------
    // A failing strobe is not debiased: it moves us to ALARM and the buffer
    // is flushed on the same edge anyway.
    assign run_strobe = (state_q == RUN) && bus.raw_valid && !fail;
    // Pair 10 -> 1, 01 -> 0: the output is simply the first bit of the pair.
    assign push       = run_strobe && pair_vld_q && (pair_bit_q != bus.raw_bit);

    // Flag is held clear outside RUN so the first RUN strobe is a pair-first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_vld_q <= 1'b0;
            pair_bit_q <= 1'b0;
        end else if (state_q != RUN) begin
            pair_vld_q <= 1'b0;
        end else if (run_strobe) begin
            pair_vld_q <= ~pair_vld_q;
            if (!pair_vld_q)
                pair_bit_q <= bus.raw_bit;
        end
    end

    // ---------------- bit FIFO ----------------
    assign pop     = bus.trng_next && bus.bit_avail;
    // A pop frees the head slot this edge, so a full FIFO still takes a push.
    assign do_push = push && ((cnt_q != CW'(BUF_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[tail_q] <= pair_bit_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else if (fail) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + PW'(1);
            if (pop)     head_q <= head_q + PW'(1);
            case ({do_push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.ready       = (state_q == RUN);
    assign bus.alarm       = (state_q == ALARM);
    assign bus.alarm_cause = cause_q;
    assign bus.bit_avail   = bus.ready && (cnt_q != '0);
    assign bus.trng_bit    = bus.bit_avail & mem[head_q];
endmodule

// File: tb/tb_trng_conditioner.sv
module tb_trng_conditioner;
    localparam int BUF_DEPTH    = 4;
    localparam int RCT_CUTOFF   = 12;
    localparam int APT_WINDOW   = 16;
    localparam int APT_CUTOFF   = 13;
    localparam int STARTUP_BITS = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    trng_conditioner_if bus();

    trng_conditioner #(
        .BUF_DEPTH    (BUF_DEPTH),
        .RCT_CUTOFF   (RCT_CUTOFF),
        .APT_WINDOW   (APT_WINDOW),
        .APT_CUTOFF   (APT_CUTOFF),
        .STARTUP_BITS (STARTUP_BITS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: whole-transaction rules on plain counters and queues.
    bit       m_alarm, m_ready;
    bit [1:0] m_cause;
    int       m_run, m_wpos, m_wones, m_su;
    bit       m_prev;
    bit       m_pair[$];
    bit       m_fq[$];

    task automatic model_reset();
        m_alarm = 0; m_ready = 0; m_cause = 0;
        m_run = 0; m_wpos = 0; m_wones = 0; m_su = 0; m_prev = 0;
        m_pair.delete(); m_fq.delete();
    endtask

    task automatic model_step(input bit rv, input bit rb, input bit nx, input bit clr);
        bit pop, rct, apt, f;
        if (m_alarm) begin
            if (clr) begin
                m_alarm = 0; m_cause = 0;
                m_run = 0; m_wpos = 0; m_wones = 0; m_su = 0;
            end
            return;
        end
        pop = nx && m_ready && (m_fq.size() > 0);
        if (rv) begin
            m_run  = (m_run > 0 && rb == m_prev) ? m_run + 1 : 1;
            m_prev = rb;
            rct    = (m_run == RCT_CUTOFF);
            m_wones += int'(rb);
            m_wpos++;
            apt = 0;
            if (m_wpos == APT_WINDOW) begin
                apt = (m_wones >= APT_CUTOFF) || (APT_WINDOW - m_wones >= APT_CUTOFF);
                m_wpos = 0; m_wones = 0;
            end
            if (rct || apt) begin
                m_alarm = 1;
                m_ready = 0;
                m_cause = m_cause | {apt, rct};
                m_fq.delete();
                m_pair.delete();
                return;
            end
            if (!m_ready) begin
                m_su++;
                if (m_su == STARTUP_BITS) begin
                    m_ready = 1; m_su = 0; m_pair.delete();
                end
            end else begin
                if (pop) begin
                    void'(m_fq.pop_front());
                    pop = 0;
                end
                if (m_pair.size() == 0) begin
                    m_pair.push_back(rb);
                end else begin
                    f = m_pair.pop_front();
                    if (f != rb && m_fq.size() < BUF_DEPTH)
                        m_fq.push_back(f);
                end
            end
        end
        if (pop) void'(m_fq.pop_front());
    endtask

    task automatic compare_all();
        bit ea, eb;
        ea = m_ready && (m_fq.size() > 0);
        eb = ea ? m_fq[0] : 1'b0;
        chk("ready",       32'(bus.ready),       32'(m_ready));
        chk("alarm",       32'(bus.alarm),       32'(m_alarm));
        chk("alarm_cause", 32'(bus.alarm_cause), 32'(m_cause));
        chk("bit_avail",   32'(bus.bit_avail),   32'(ea));
        chk("trng_bit",    32'(bus.trng_bit),    32'(eb));
    endtask

    task automatic cyc(input bit rv, input bit rb, input bit nx, input bit clr);
        bus.raw_valid = rv;
        bus.raw_bit   = rb;
        bus.trng_next = nx;
        bus.alarm_clr = clr;
        @(posedge clk);
        model_step(rv, rb, nx, clr);
        #1;
        compare_all();
    endtask

    task automatic strobe(input bit b);
        cyc(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic pop_cyc();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Alternate bits until the next strobe opens a fresh APT window.
    task automatic pad_win();
        for (int i = 0; i < APT_WINDOW && m_wpos != 0 && !m_alarm; i++)
            strobe(~m_prev);
    endtask

    task automatic clear_and_start();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < STARTUP_BITS; i++) strobe(i[0]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp4 [4];
        int bias;
        bus.raw_valid = 0; bus.raw_bit = 0; bus.trng_next = 0; bus.alarm_clr = 0;
        model_reset();
        #12;
        chk("rst_ready",     32'(bus.ready),       32'd0);
        chk("rst_alarm",     32'(bus.alarm),       32'd0);
        chk("rst_cause",     32'(bus.alarm_cause), 32'd0);
        chk("rst_bit_avail", 32'(bus.bit_avail),   32'd0);
        chk("rst_trng_bit",  32'(bus.trng_bit),    32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Startup: ready only after the 4th strobe.
        strobe(1); strobe(0); strobe(1);
        chk("startup_not_ready", 32'(bus.ready), 32'd0);
        strobe(0);
        chk("startup_ready", 32'(bus.ready), 32'd1);
        strobe(0);
        chk("pair_first_no_bit", 32'(bus.bit_avail), 32'd0);
        strobe(1);
        chk("pair01_avail", 32'(bus.bit_avail), 32'd1);
        chk("pair01_bit",   32'(bus.trng_bit),  32'd0);
        pop_cyc();

        // Pairs 10,11,00,01 -> exactly bits 1,0.
        strobe(1); strobe(0); strobe(1); strobe(1);
        strobe(0); strobe(0); strobe(0); strobe(1);
        chk("pairs_head1", 32'(bus.trng_bit), 32'd1);
        pop_cyc();
        chk("pairs_head2", 32'(bus.trng_bit), 32'd0);
        chk("pairs_avail2", 32'(bus.bit_avail), 32'd1);
        pop_cyc();
        chk("pairs_empty", 32'(bus.bit_avail), 32'd0);

        // Overfill: 6 debiased bits 1,0,1,1,0,1 into a 4-deep FIFO.
        strobe(1); strobe(0); strobe(0); strobe(1); strobe(1); strobe(0);
        strobe(1); strobe(0); strobe(0); strobe(1); strobe(1); strobe(0);
        exp4 = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            chk("full_order", 32'(bus.trng_bit), 32'(exp4[i]));
            pop_cyc();
        end
        chk("full_drained", 32'(bus.bit_avail), 32'd0);

        // Count 2, then push and pop on the same edge.
        strobe(1); strobe(0); strobe(0); strobe(1);
        strobe(1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pushpop_head", 32'(bus.trng_bit), 32'd0);
        pop_cyc();
        chk("pushpop_next", 32'(bus.trng_bit), 32'd1);
        pop_cyc();
        chk("pushpop_cnt2", 32'(bus.bit_avail), 32'd0);

        // RCT: 11 ones then 0 is tolerated, 12 ones alarms.
        pad_win();
        for (int i = 0; i < 11; i++) strobe(1);
        strobe(0); strobe(0); strobe(0); strobe(1); strobe(0);
        chk("rct_11_no_alarm", 32'(bus.alarm), 32'd0);
        strobe(1); strobe(0);
        pad_win();
        for (int i = 0; i < 12; i++) strobe(1);
        chk("rct_alarm",     32'(bus.alarm),       32'd1);
        chk("rct_cause",     32'(bus.alarm_cause), 32'd1);
        chk("rct_flush",     32'(bus.bit_avail),   32'd0);
        chk("rct_trng_bit0", 32'(bus.trng_bit),    32'd0);
        strobe(0); strobe(1);
        chk("alarm_sticky", 32'(bus.alarm), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_alarm", 32'(bus.alarm),       32'd0);
        chk("clr_cause", 32'(bus.alarm_cause), 32'd0);
        chk("clr_ready", 32'(bus.ready),       32'd0);
        strobe(1); strobe(0); strobe(1);
        chk("restart_not_ready", 32'(bus.ready), 32'd0);
        strobe(0);
        chk("restart_ready", 32'(bus.ready), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_outside_alarm", 32'(bus.ready), 32'd1);

        // APT: 12 ones in a window passes, 13 fails at the window-end edge.
        pad_win();
        for (int i = 0; i < 10; i++) strobe(1);
        strobe(0); strobe(1); strobe(1); strobe(0); strobe(0); strobe(0);
        chk("apt_12_no_alarm", 32'(bus.alarm), 32'd0);
        for (int i = 0; i < 10; i++) strobe(1);
        strobe(0); strobe(1); strobe(1); strobe(1); strobe(0);
        chk("apt_pre_end", 32'(bus.alarm), 32'd0);
        strobe(0);
        chk("apt_alarm", 32'(bus.alarm),       32'd1);
        chk("apt_cause", 32'(bus.alarm_cause), 32'd2);
        clear_and_start();

        // Randomized traffic with shifting bias to provoke both tests.
        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) bias = ($urandom_range(0, 2) == 0) ? 85 : 50;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 99) < bias,
                $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end

        // Async reset mid-RUN with a non-empty FIFO.
        for (int i = 0; i < 200 && !(m_ready && m_fq.size() > 0); i++) begin
            if (m_alarm) cyc(1'b0, 1'b0, 1'b0, 1'b1);
            else         strobe(~m_prev);
        end
        chk("pre_rst_avail", 32'(bus.bit_avail), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_ready",     32'(bus.ready),       32'd0);
        chk("arst_alarm",     32'(bus.alarm),       32'd0);
        chk("arst_cause",     32'(bus.alarm_cause), 32'd0);
        chk("arst_bit_avail", 32'(bus.bit_avail),   32'd0);
        chk("arst_trng_bit",  32'(bus.trng_bit),    32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) strobe(i[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
